// File: rtl/ahb_cache_arbiter_pkg.sv
// Shared AHB-Lite constants and enums for the cache-to-bus arbiter.
package ahb_cache_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Bus owner: instruction fetch side (F) or data memory side (M).
  typedef enum logic {
    OWN_F = 1'b0,
    OWN_M = 1'b1
  } owner_t;

  // One word transfer walks IDLE -> ADDR -> DATA.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

endpackage

// File: rtl/ahb_arb_priority.sv
// Fresh-request arbiter: picks a new owner when the bus is unlocked.
module ahb_arb_priority
  import ahb_cache_arbiter_pkg::*;
#(
  parameter bit DataPriority = 1'b1
) (
  input  logic   req_m,
  input  logic   req_f,
  output logic   grant_valid,
  output owner_t grant
);

  // Single requester wins outright; a tie goes to the preferred side.
  always_comb begin
    grant_valid = req_m | req_f;
    grant       = OWN_M;
    if (req_m && req_f) begin
      grant = DataPriority ? OWN_M : OWN_F;
    end else if (req_f) begin
      grant = OWN_F;
    end
  end

endmodule

// File: rtl/ahb_cache_arbiter.sv
// Serialises single-word transfers from the instruction and data caches
// onto one AHB-Lite master port, holding ownership for a whole block.
module ahb_cache_arbiter
  import ahb_cache_arbiter_pkg::*;
#(
  parameter bit DataPriority = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HRequestM,
  input  logic        HWriteM,
  input  logic [31:0] HAddrM,
  input  logic [31:0] HWDataM,
  input  logic        HRequestF,
  input  logic [31:0] HAddrF,
  output logic        BusReady,
  output logic        HReadyF,
  output logic [31:0] HRData,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        locked_q, locked_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;

  logic        own_req;
  logic [31:0] own_addr;
  logic        own_write;
  logic [31:0] own_wdata;
  logic        grant_valid;
  owner_t      grant;

  ahb_arb_priority #(
    .DataPriority(DataPriority)
  ) u_prio (
    .req_m      (HRequestM),
    .req_f      (HRequestF),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // Select the current owner's request, address and write attributes.
  always_comb begin
    if (owner_q == OWN_M) begin
      own_req   = HRequestM;
      own_addr  = HAddrM;
      own_write = HWriteM;
      own_wdata = HWDataM;
    end else begin
      own_req   = HRequestF;
      own_addr  = HAddrF;
      own_write = 1'b0;
      own_wdata = '0;
    end
  end

  // State register and captured data-phase attributes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_M;
      locked_q <= 1'b0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
    end
  end

  // Next-state logic: continue a locked block or arbitrate afresh.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    case (state_q)
      ST_IDLE: begin
        if (locked_q && own_req) begin
          state_d = ST_ADDR;
        end else begin
          // Releasing the lock and re-arbitrating share this cycle, so a
          // waiting requester is granted without an extra idle cycle.
          locked_d = 1'b0;
          if (grant_valid) begin
            owner_d  = grant;
            locked_d = 1'b1;
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          wdata_d = own_wdata;
          write_d = own_write;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and ready outputs decoded from the current state.
  always_comb begin
    HTRANS   = HTRANS_IDLE;
    HADDR    = '0;
    HWRITE   = 1'b0;
    HWDATA   = '0;
    BusReady = 1'b0;
    HReadyF  = 1'b0;
    case (state_q)
      ST_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = own_addr;
        HWRITE = own_write;
      end
      ST_DATA: begin
        HWDATA = write_q ? wdata_q : '0;
        if (HREADY) begin
          BusReady = (owner_q == OWN_M);
          HReadyF  = (owner_q == OWN_F);
        end
      end
      default: ;
    endcase
  end

  assign HSIZE  = HSIZE_WORD;
  assign HRData = HRDATA;

endmodule
